// File: rtl/fft_addr_gen.sv
// Purpose: address/twiddle sequencer for an in-place radix-2 DIT FFT (N = 2..MAX_N).
// Latency: first descriptor one cycle after start is accepted, then one descriptor per cycle.
// Backpressure: bf_valid/bf_ready; while stalled, every descriptor output holds its value.
//
// Ports: clk/rst_n (async active-low); start + n_cfg request a pass; bf_valid/bf_ready
// handshake the descriptor {addr_a, addr_b, tw_k, tw_n, stage, last_stage};
// busy spans the pass; done pulses at the end; cfg_err pulses when start is refused.
// Optional build macro FFT_ADDR_GEN_STAGE_GAP_EN inserts a 2-cycle bubble between stages
// so that writes from the previous stage drain before the next stage reads them.
module fft_addr_gen #(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_cfg,
  output logic                  bf_valid,
  input  logic                  bf_ready,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [ADDR_WIDTH-1:0] tw_k,
  output logic [ADDR_WIDTH:0]   tw_n,
  output logic [2:0]            stage,
  output logic                  last_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef FFT_ADDR_GEN_STAGE_GAP_EN
  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
  logic gap_cnt, gap_cnt_nxt;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   n_reg, n_nxt;
  logic [2:0]            lg_last, lg_nxt;      // log2(N)-1, index of the final stage
  logic [ADDR_WIDTH-1:0] b, b_nxt;             // butterfly index within the stage
  logic [2:0]            stage_nxt;
  logic                  valid_nxt, busy_nxt, done_nxt, err_nxt, last_nxt;
  logic [ADDR_WIDTH-1:0] addr_a_nxt, addr_b_nxt, tw_k_nxt;
  logic [ADDR_WIDTH:0]   tw_n_nxt;
  logic                  load;                 // present a fresh descriptor for (stage_nxt, b_nxt)

  // n_cfg legality and log2 decode: only exact powers of two from 2 to MAX_N.
  logic                  cfg_ok;
  logic [2:0]            cfg_lg;
  always_comb begin
    cfg_ok = 1'b0;
    cfg_lg = 3'd0;
    for (int i = 1; i <= ADDR_WIDTH; i++) begin
      if (n_cfg == (ONE << i)) begin
        cfg_ok = 1'b1;
        cfg_lg = 3'(i - 1);
      end
    end
  end

  logic [ADDR_WIDTH:0] b_last;
  assign b_last = (n_reg >> 1) - ONE;

  // Descriptor math: half = 2^s, j = b mod half, g = b / half.
  logic [ADDR_WIDTH:0]   half_w;
  logic [ADDR_WIDTH-1:0] mask_w, j_w, g_w, a_w;

  always_comb begin
    state_nxt = state;
    n_nxt     = n_reg;
    lg_nxt    = lg_last;
    stage_nxt = stage;
    b_nxt     = b;
    valid_nxt = bf_valid;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    load      = 1'b0;
`ifdef FFT_ADDR_GEN_STAGE_GAP_EN
    gap_cnt_nxt = gap_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            n_nxt     = n_cfg;
            lg_nxt    = cfg_lg;
            stage_nxt = 3'd0;
            b_nxt     = '0;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
            load      = 1'b1;
            state_nxt = RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (bf_valid && bf_ready) begin
          if ({1'b0, b} == b_last) begin
            if (stage == lg_last) begin
              valid_nxt = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
              state_nxt = DONE;
            end else begin
              stage_nxt = stage + 3'd1;
              b_nxt     = '0;
`ifdef FFT_ADDR_GEN_STAGE_GAP_EN
              valid_nxt   = 1'b0;
              gap_cnt_nxt = 1'b0;
              state_nxt   = GAP;
`else
              load = 1'b1;
`endif
            end
          end else begin
            b_nxt = b + ADDR_WIDTH'(1);
            load  = 1'b1;
          end
        end
      end
`ifdef FFT_ADDR_GEN_STAGE_GAP_EN
      GAP: begin
        // Two bubble cycles: gap_cnt 0 then 1, descriptor returns after the second.
        if (gap_cnt) begin
          valid_nxt = 1'b1;
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          gap_cnt_nxt = 1'b1;
        end
      end
`endif
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    half_w = ONE << stage_nxt;
    mask_w = ADDR_WIDTH'(half_w - ONE);
    j_w    = b_nxt & mask_w;
    g_w    = b_nxt >> stage_nxt;
    a_w    = (g_w << (stage_nxt + 3'd1)) | j_w;

    addr_a_nxt = load ? a_w : addr_a;
    addr_b_nxt = load ? (a_w | ADDR_WIDTH'(half_w)) : addr_b;
    tw_k_nxt   = load ? j_w : tw_k;
    tw_n_nxt   = load ? (half_w << 1) : tw_n;
    last_nxt   = load ? (stage_nxt == lg_nxt) : last_stage;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_reg      <= '0;
      lg_last    <= '0;
      b          <= '0;
      stage      <= '0;
      bf_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      tw_k       <= '0;
      tw_n       <= '0;
      last_stage <= 1'b0;
`ifdef FFT_ADDR_GEN_STAGE_GAP_EN
      gap_cnt    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      n_reg      <= n_nxt;
      lg_last    <= lg_nxt;
      b          <= b_nxt;
      stage      <= stage_nxt;
      bf_valid   <= valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      cfg_err    <= err_nxt;
      addr_a     <= addr_a_nxt;
      addr_b     <= addr_b_nxt;
      tw_k       <= tw_k_nxt;
      tw_n       <= tw_n_nxt;
      last_stage <= last_nxt;
`ifdef FFT_ADDR_GEN_STAGE_GAP_EN
      gap_cnt    <= gap_cnt_nxt;
`endif
    end
  end

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 Parameter MAX_N, default 32; largest supported transform size.
REQ-002 Parameter ADDR_WIDTH, default $clog2(MAX_N); width of data-memory addresses and twiddle index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin one FFT pass.
REQ-006 n_cfg  input  ADDR_WIDTH+1  transform size N; legal values are 2, 4, 8, 16 and 32.
REQ-007 bf_valid  output  1  the current butterfly descriptor is valid.
REQ-008 bf_ready  input  1  the downstream butterfly accepts the descriptor.
REQ-009 addr_a, addr_b  output  ADDR_WIDTH each  in-place memory addresses of the butterfly operands.
REQ-010 tw_k  output  ADDR_WIDTH  twiddle index for the twiddle ROM k port.
REQ-011 tw_n  output  ADDR_WIDTH+1  twiddle size for the twiddle ROM n port.
REQ-012 stage  output  3  current stage number s, starting at 0.
REQ-013 last_stage  output  1  high when s = log2(N)-1.
REQ-014 busy  output  1  high from start acceptance until done.
REQ-015 done  output  1  one-cycle pulse at the end of the pass.
REQ-016 cfg_err  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 Supported algorithm: radix-2 DIT, in-place, log2(N) stages; each stage issues N/2 butterflies b = 0..N/2-1 in ascending order.
REQ-018 Per butterfly: half = 2^s, j = b mod half, g = b / half, addr_a = g*2^(s+1) + j, addr_b = addr_a + half, tw_k = j, tw_n = 2^(s+1).
REQ-019 All outputs are registered; no combinational path from any input to any output.
REQ-020 FSM states: IDLE, RUN, GAP (present only under the macro), DONE.
REQ-021 IDLE with start=1 and legal n_cfg: latch N, set s=0 and b=0, assert busy, enter RUN; bf_valid rises on the next cycle.
REQ-022 IDLE with start=1 and illegal n_cfg: pulse cfg_err for one cycle and remain in IDLE.
REQ-023 start is ignored while busy=1; N is latched and n_cfg changes mid-pass have no effect.
REQ-024 Handshake: a descriptor transfers when bf_valid and bf_ready are both high; all descriptor outputs hold stable while bf_valid=1 and bf_ready=0.
REQ-025 On a transfer that is not the last of a stage, b increments and the next descriptor is presented on the following cycle (throughput of 1 per cycle).
REQ-026 On a transfer of the last butterfly of a non-final stage: s increments, b clears, and control goes to RUN (or to GAP under the macro).
REQ-027 On a transfer of the last butterfly of the last stage: bf_valid drops and control goes to DONE.
REQ-028 DONE: pulse done for one cycle, clear busy in the same cycle, and return to IDLE; a start in the following cycle is accepted.
REQ-029 For N=2 the pass is a single butterfly (0,1,k=0,n=2) with last_stage=1.
REQ-030 Total transfers per pass is exactly (N/2)*log2(N).

Reset
REQ-031 While rst_n=0: state=IDLE; bf_valid, busy, done and cfg_err are 0; addr_a, addr_b, tw_k, tw_n, stage and last_stage are 0.
REQ-032 Reset asserted mid-pass aborts immediately with no done pulse; after release the block waits in IDLE for a new start.

Configuration
REQ-033 Macro FFT_ADDR_GEN_STAGE_GAP_EN defined: after each non-final stage, control sits in GAP for 2 cycles with bf_valid=0 before the next stage's first descriptor (pipeline drain for read-after-write).
REQ-034 Macro undefined: the GAP state does not exist and stages run back-to-back with no idle cycle.

Verification
REQ-035 N=2, bf_ready=1: start -> one descriptor (a0,b1,k0,n2,last_stage=1), done pulse 2 cycles after start.
REQ-036 N=8, bf_ready=1, no macro: 12 consecutive descriptors; stage1 order (0,2,k0),(1,3,k1),(4,6,k0),(5,7,k1) with n=4; stage2 a=0..3, b=4..7, k=0..3, n=8.
REQ-037 N=32 with random bf_ready: 80 transfers, outputs stable across every stall, single done pulse.
REQ-038 n_cfg=12 with start -> cfg_err pulse, busy stays 0; start with n_cfg=16 during a pass -> ignored.
REQ-039 Macro defined, N=4: exactly 2 bf_valid=0 cycles between stage0 and stage1; none with the macro undefined.
REQ-040 rst_n low mid-stage of N=16 -> all outputs 0 and no done pulse; a new start afterwards completes normally.
